// File: rtl/mem_bus_pkg.sv
// Shared constants for the CPU-to-memory bus bridge: FSM encodings,
// default timeout and the word-alignment mask.
package mem_bus_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
  localparam logic [1:0] ST_ERR  = 2'd3;

  localparam logic [15:0] DEFAULT_TIMEOUT = 16'd255;
  localparam logic [1:0]  ALIGN_MASK      = 2'b11;

endpackage

// File: rtl/bus_timeout_counter.sv
// Saturating 16-bit wait counter; o_expired flags that the increment taken
// this cycle brings the count up to TIMEOUT.
module bus_timeout_counter
  import mem_bus_pkg::*;
#(
  parameter logic [15:0] TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  logic [15:0] r_count;
  logic [15:0] w_count_inc;

  // Saturating increment: never wraps back to zero.
  always_comb begin
    w_count_inc = r_count;
    if (r_count == 16'hFFFF) begin
      w_count_inc = r_count;
    end else begin
      w_count_inc = r_count + 16'd1;
    end
  end

  assign o_expired = i_enable && (w_count_inc >= TIMEOUT);

  // Count register with clear priority over enable.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= 16'd0;
    end else if (i_clear) begin
      r_count <= 16'd0;
    end else if (i_enable) begin
      r_count <= w_count_inc;
    end else begin
      r_count <= r_count;
    end
  end

endmodule

// File: rtl/mem_bus_bridge.sv
// Converts single-cycle CPU memory requests into a registered valid/ack bus
// transaction with ready/err completion pulses and registered read data.
module mem_bus_bridge
  import mem_bus_pkg::*;
#(
  parameter int          ADDR_W  = 32,
  parameter int          DATA_W  = 32,
  parameter logic [15:0] TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ready,
  output logic              cpu_err,
  output logic              busy,
  output logic              bus_valid,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_ack,
  input  logic [DATA_W-1:0] bus_rdata
);

  logic [1:0]        r_state;
  logic [1:0]        w_state_next;
  logic              w_accept;
  logic              w_misaligned;
  logic              w_cnt_enable;
  logic              w_expired;
  logic              r_cpu_ready;
  logic              r_cpu_err;
  logic              r_busy;
  logic              r_bus_valid;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_cpu_rdata;

  assign w_misaligned = (cpu_addr[1:0] & ALIGN_MASK) != 2'b00;
  assign w_cnt_enable = (r_state == ST_REQ) && !bus_ack;

  bus_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk       (clk),
    .reset     (reset),
    .i_clear   (w_accept),
    .i_enable  (w_cnt_enable),
    .o_expired (w_expired)
  );

  // Next-state logic; in REQ an ack takes priority over expiry.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (cpu_req) begin
          if (w_misaligned) begin
            w_state_next = ST_ERR;
          end else begin
            w_state_next = ST_REQ;
            w_accept     = 1'b1;
          end
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (bus_ack) begin
          w_state_next = ST_DONE;
        end else if (w_expired) begin
          w_state_next = ST_ERR;
        end else begin
          w_state_next = ST_REQ;
        end
      end
      ST_DONE: w_state_next = ST_IDLE;
      ST_ERR:  w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // State, registered outputs decoded from the next state, request capture and read data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_bus_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_cpu_ready <= 1'b0;
      r_cpu_err   <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_cpu_rdata <= '0;
    end else begin
      r_state     <= w_state_next;
      r_bus_valid <= (w_state_next == ST_REQ);
      r_busy      <= (w_state_next != ST_IDLE);
      r_cpu_ready <= (w_state_next == ST_DONE);
      r_cpu_err   <= (w_state_next == ST_ERR);
      if (w_accept) begin
        r_we    <= cpu_we;
        r_addr  <= {cpu_addr[ADDR_W-1:2], 2'b00};
        r_wdata <= cpu_wdata;
      end else begin
        r_we    <= r_we;
        r_addr  <= r_addr;
        r_wdata <= r_wdata;
      end
      if ((r_state == ST_REQ) && bus_ack && !r_we) begin
        r_cpu_rdata <= bus_rdata;
      end else begin
        r_cpu_rdata <= r_cpu_rdata;
      end
    end
  end

  assign cpu_rdata = r_cpu_rdata;
  assign cpu_ready = r_cpu_ready;
  assign cpu_err   = r_cpu_err;
  assign busy      = r_busy;
  assign bus_valid = r_bus_valid;
  assign bus_we    = r_we;
  assign bus_addr  = r_addr;
  assign bus_wdata = r_wdata;

endmodule

// File: tb/tb_mem_bus_bridge.sv
// Directed self-checking bench for mem_bus_bridge, built with TIMEOUT=4 so
// the timeout path is reachable in a few cycles.
module tb_mem_bus_bridge;

  logic        clk;
  logic        reset;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_ready;
  logic        cpu_err;
  logic        busy;
  logic        bus_valid;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  int checks;
  int failures;

  mem_bus_bridge #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .TIMEOUT (16'd4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_ready (cpu_ready),
    .cpu_err   (cpu_err),
    .busy      (busy),
    .bus_valid (bus_valid),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_ack   (bus_ack),
    .bus_rdata (bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge (start of the next cycle).
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_wdata = wdata;
  endtask

  task automatic test_reset();
    #20;
    checks++;
    if ({bus_valid, cpu_ready, cpu_err, busy, bus_we} !== 5'b00000) begin
      failures++;
      $display("FAIL reset_flags got=%b want=00000", {bus_valid, cpu_ready, cpu_err, busy, bus_we});
    end
    checks++;
    if (cpu_rdata !== 32'h0) begin
      failures++;
      $display("FAIL reset_rdata got=%h want=00000000", cpu_rdata);
    end
    checks++;
    if ((bus_addr !== 32'h0) || (bus_wdata !== 32'h0)) begin
      failures++;
      $display("FAIL reset_bus got addr=%h wdata=%h want 0/0", bus_addr, bus_wdata);
    end
  endtask

  task automatic test_aligned_read();
    issue(1'b0, 32'h0000_0010, 32'h0);
    tick();
    cpu_req = 1'b0;
    checks++;
    if ((bus_valid !== 1'b1) || (bus_addr !== 32'h10) || (bus_we !== 1'b0) || (busy !== 1'b1)) begin
      failures++;
      $display("FAIL read_c1 got valid=%b addr=%h we=%b busy=%b want 1/00000010/0/1", bus_valid, bus_addr, bus_we, busy);
    end
    tick();
    bus_ack   = 1'b1;
    bus_rdata = 32'hE3A0_1005;
    tick();
    bus_ack   = 1'b0;
    bus_rdata = 32'h0;
    checks++;
    if ((cpu_ready !== 1'b1) || (cpu_err !== 1'b0) || (bus_valid !== 1'b0)) begin
      failures++;
      $display("FAIL read_c3 got ready=%b err=%b valid=%b want 1/0/0", cpu_ready, cpu_err, bus_valid);
    end
    checks++;
    if (cpu_rdata !== 32'hE3A0_1005) begin
      failures++;
      $display("FAIL read_data got=%h want=e3a01005", cpu_rdata);
    end
    tick();
    checks++;
    if ((cpu_ready !== 1'b0) || (busy !== 1'b0)) begin
      failures++;
      $display("FAIL read_c4 got ready=%b busy=%b want 0/0", cpu_ready, busy);
    end
  endtask

  task automatic test_write_wait();
    int nvalid;
    int nbad;
    nvalid = 0;
    nbad   = 0;
    issue(1'b1, 32'h0000_0100, 32'hDEAD_BEEF);
    tick();
    cpu_req = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      if (c == 4) begin
        bus_ack   = 1'b1;
        bus_rdata = 32'h1234_5678;
      end
      if (bus_valid === 1'b1) nvalid++;
      if ((bus_addr !== 32'h100) || (bus_wdata !== 32'hDEAD_BEEF) || (bus_we !== 1'b1) || (cpu_ready !== 1'b0)) nbad++;
      tick();
    end
    bus_ack   = 1'b0;
    bus_rdata = 32'h0;
    checks++;
    if (nvalid != 4) begin
      failures++;
      $display("FAIL write_valid_cycles got=%0d want=4", nvalid);
    end
    checks++;
    if (nbad != 0) begin
      failures++;
      $display("FAIL write_bus_stable got=%0d bad cycles want=0", nbad);
    end
    checks++;
    if ((cpu_ready !== 1'b1) || (bus_valid !== 1'b0) || (cpu_err !== 1'b0)) begin
      failures++;
      $display("FAIL write_done got ready=%b valid=%b err=%b want 1/0/0", cpu_ready, bus_valid, cpu_err);
    end
    checks++;
    if (cpu_rdata !== 32'hE3A0_1005) begin
      failures++;
      $display("FAIL write_rdata_hold got=%h want=e3a01005", cpu_rdata);
    end
    tick();
    checks++;
    if (cpu_ready !== 1'b0) begin
      failures++;
      $display("FAIL write_single_ready got=%b want=0", cpu_ready);
    end
  endtask

  task automatic test_misaligned();
    issue(1'b0, 32'h0000_0102, 32'h0);
    tick();
    cpu_req = 1'b0;
    checks++;
    if ((cpu_err !== 1'b1) || (bus_valid !== 1'b0) || (cpu_ready !== 1'b0)) begin
      failures++;
      $display("FAIL misalign_c1 got err=%b valid=%b ready=%b want 1/0/0", cpu_err, bus_valid, cpu_ready);
    end
    tick();
    checks++;
    if ((cpu_err !== 1'b0) || (busy !== 1'b0) || (bus_valid !== 1'b0) || (cpu_rdata !== 32'hE3A0_1005)) begin
      failures++;
      $display("FAIL misalign_c2 got err=%b busy=%b valid=%b rdata=%h want 0/0/0/e3a01005", cpu_err, busy, bus_valid, cpu_rdata);
    end
  endtask

  task automatic test_timeout(input logic ack_last);
    int nvalid;
    int nerr;
    nvalid = 0;
    nerr   = 0;
    issue(1'b0, 32'h0000_0040, 32'h0);
    tick();
    cpu_req = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      if ((c == 4) && ack_last) begin
        bus_ack   = 1'b1;
        bus_rdata = 32'hA5A5_0004;
      end
      if (bus_valid === 1'b1) nvalid++;
      if ((cpu_err !== 1'b0) || (cpu_ready !== 1'b0)) nerr++;
      tick();
    end
    bus_ack   = 1'b0;
    bus_rdata = 32'h0;
    checks++;
    if ((nvalid != 4) || (nerr != 0)) begin
      failures++;
      $display("FAIL timeout_req_cycles ack=%b got valid=%0d early_pulses=%0d want 4/0", ack_last, nvalid, nerr);
    end
    checks++;
    if ((cpu_err !== ~ack_last) || (cpu_ready !== ack_last) || (bus_valid !== 1'b0)) begin
      failures++;
      $display("FAIL timeout_end ack=%b got err=%b ready=%b valid=%b want err=%b ready=%b valid=0",
               ack_last, cpu_err, cpu_ready, bus_valid, ~ack_last, ack_last);
    end
    checks++;
    if (cpu_rdata !== (ack_last ? 32'hA5A5_0004 : 32'hE3A0_1005)) begin
      failures++;
      $display("FAIL timeout_rdata ack=%b got=%h", ack_last, cpu_rdata);
    end
    tick();
    checks++;
    if ((busy !== 1'b0) || (cpu_err !== 1'b0) || (cpu_ready !== 1'b0)) begin
      failures++;
      $display("FAIL timeout_idle got busy=%b err=%b ready=%b want 0/0/0", busy, cpu_err, cpu_ready);
    end
  endtask

  task automatic test_reset_mid_req();
    int npulse;
    npulse = 0;
    issue(1'b0, 32'h0000_0080, 32'h0);
    tick();
    cpu_req = 1'b0;
    tick();
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ((bus_valid !== 1'b0) || (busy !== 1'b0) || (cpu_rdata !== 32'h0)) begin
      failures++;
      $display("FAIL rst_mid_async got valid=%b busy=%b rdata=%h want 0/0/0", bus_valid, busy, cpu_rdata);
    end
    for (int c = 0; c < 2; c++) begin
      tick();
      if ((cpu_ready !== 1'b0) || (cpu_err !== 1'b0) || (bus_valid !== 1'b0)) npulse++;
    end
    reset = 1'b1;
    tick();
    for (int c = 0; c < 2; c++) begin
      if ((cpu_ready !== 1'b0) || (cpu_err !== 1'b0) || (bus_valid !== 1'b0)) npulse++;
      tick();
    end
    checks++;
    if (npulse != 0) begin
      failures++;
      $display("FAIL rst_mid_no_pulse got=%0d bad cycles want=0", npulse);
    end
    issue(1'b0, 32'h0000_0010, 32'h0);
    tick();
    cpu_req   = 1'b0;
    bus_ack   = 1'b1;
    bus_rdata = 32'h0BAD_F00D;
    tick();
    bus_ack   = 1'b0;
    bus_rdata = 32'h0;
    checks++;
    if ((cpu_ready !== 1'b1) || (cpu_rdata !== 32'h0BAD_F00D)) begin
      failures++;
      $display("FAIL rst_mid_recover got ready=%b rdata=%h want 1/0badf00d", cpu_ready, cpu_rdata);
    end
    tick();
  endtask

  task automatic test_req_while_busy();
    int nbad;
    int nready;
    nbad   = 0;
    nready = 0;
    issue(1'b0, 32'h0000_0010, 32'h0);
    tick();
    cpu_addr = 32'h0000_0020;
    for (int c = 1; c <= 3; c++) begin
      if (c == 3) begin
        bus_ack   = 1'b1;
        bus_rdata = 32'h1111_2222;
      end
      if ((bus_valid !== 1'b1) || (bus_addr !== 32'h10)) nbad++;
      tick();
    end
    bus_ack   = 1'b0;
    bus_rdata = 32'h0;
    cpu_req   = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (cpu_ready === 1'b1) nready++;
      if (bus_valid !== 1'b0) nbad++;
      tick();
    end
    checks++;
    if (nbad != 0) begin
      failures++;
      $display("FAIL busy_req_bus got=%0d bad cycles want=0", nbad);
    end
    checks++;
    if ((nready != 1) || (cpu_rdata !== 32'h1111_2222)) begin
      failures++;
      $display("FAIL busy_req_ready got pulses=%0d rdata=%h want 1/11112222", nready, cpu_rdata);
    end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    reset     = 1'b1;
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = 32'h0;
    cpu_wdata = 32'h0;
    bus_ack   = 1'b0;
    bus_rdata = 32'h0;
    #1;
    reset = 1'b0;
    test_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    tick();
    test_aligned_read();
    test_write_wait();
    test_misaligned();
    test_timeout(1'b0);
    test_timeout(1'b1);
    test_reset_mid_req();
    test_req_while_busy();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
